// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle subtractor computing (a - b - bin) mod 2^WIDTH, DIGIT bits per
// clock, with the borrow carried between digits in a registered flop. One
// operation takes N = WIDTH/DIGIT processing cycles after acceptance.
//
// Handshake (start/busy/done):
//   A request is accepted on a rising edge where start=1 and busy=0. From the
//   following cycle busy=1 until the edge that processes the last digit. On
//   that edge d/bout/ovf update and done pulses high for exactly one cycle
//   with busy=0 in the same cycle. start while busy=1 is ignored. Operands
//   are captured at acceptance and may change freely afterwards.
//
// Parameters:
//   WIDTH  operand/result width (>= 1, multiple of DIGIT)
//   DIGIT  bits processed per clock
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a new operation (sampled only while idle)
//   a, b         minuend / subtrahend, WIDTH bits
//   bin          borrow-in
//   busy         operation in progress
//   done         one-cycle pulse when the result registers update
//   d            difference
//   bout         borrow-out (unsigned a < b + bin)
//   ovf          two's-complement signed overflow
//   o_dbg_state  FSM state (0 = IDLE, 1 = RUN), for observation only
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             o_dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_dig_diff;
  logic             w_br_out;
  logic [WIDTH-1:0] w_diff_next;

  // One digit of full-subtractor cells; the borrow ripples through the
  // DIGIT bits within the cycle and the final borrow goes to the flop.
  always_comb begin
    logic v_br;
    w_dig_diff = '0;
    v_br       = r_br;
    for (int i = 0; i < DIGIT; i++) begin
      w_dig_diff[i] = r_a[i] ^ r_b[i] ^ v_br;
      v_br          = (~r_a[i] & r_b[i]) | (~r_a[i] & v_br) | (r_b[i] & v_br);
    end
    w_br_out = v_br;
  end

  // New digits enter at the MSB end so that after N shifts digit 0 sits in
  // the low bits of the difference register.
  generate
    if (N == 1) begin : g_single
      assign w_diff_next = w_dig_diff;
    end else begin : g_multi
      assign w_diff_next = {w_dig_diff, r_diff[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            // Sign bits are kept separately: the shift registers lose them.
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a    <= r_a >> DIGIT;
          r_b    <= r_b >> DIGIT;
          r_br   <= w_br_out;
          r_diff <= w_diff_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_d     <= w_diff_next;
            r_bout  <= w_br_out;
            r_ovf   <= (r_a_msb != r_b_msb) && (w_diff_next[WIDTH-1] != r_a_msb);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign d           = r_d;
  assign bout        = r_bout;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Three instances share one clock and reset:
//   sel 0: WIDTH=8,  DIGIT=1 (N=8)
//   sel 1: WIDTH=16, DIGIT=4 (N=4)
//   sel 2: WIDTH=8,  DIGIT=8 (N=1)
// Expected results are packed as {ovf, bout, d[15:0]}, pushed to a per-instance
// queue when a start is accepted and popped by a monitor on each done pulse.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start8, bin8, busy8, done8, bout8, ovf8, dbg8;
  logic [7:0]  a8, b8, d8;
  logic        start16, bin16, busy16, done16, bout16, ovf16, dbg16;
  logic [15:0] a16, b16, d16;
  logic        start1, bin1, busy1, done1, bout1, ovf1, dbg1;
  logic [7:0]  a1, b1, d1;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8),
    .o_dbg_state(dbg8)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .d(d16), .bout(bout16), .ovf(ovf16),
    .o_dbg_state(dbg16)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1),
    .o_dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp8_q[$];
  logic [17:0] exp16_q[$];
  logic [17:0] exp1_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected_done(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s done pulse with empty expected queue (actual=1 expected=0)", name);
  endtask

  always @(negedge clk) begin : mon8
    logic [17:0] e;
    if (done8) begin
      if (exp8_q.size() == 0) unexpected_done("sb8");
      else begin
        e = exp8_q.pop_front();
        chk("sb8_result", 32'({ovf8, bout8, 8'h00, d8}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon16
    logic [17:0] e;
    if (done16) begin
      if (exp16_q.size() == 0) unexpected_done("sb16");
      else begin
        e = exp16_q.pop_front();
        chk("sb16_result", 32'({ovf16, bout16, d16}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [17:0] e;
    if (done1) begin
      if (exp1_q.size() == 0) unexpected_done("sb1");
      else begin
        e = exp1_q.pop_front();
        chk("sb1_result", 32'({ovf1, bout1, 8'h00, d1}), 32'(e));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic bin);
    logic [15:0] mask, am, bm, dd;
    logic [16:0] full;
    logic        bo, ov;
    mask = (w == 16) ? 16'hFFFF : 16'((32'h1 << w) - 32'h1);
    am   = a & mask;
    bm   = b & mask;
    full = {1'b0, am} - {1'b0, bm} - 17'(bin);
    dd   = full[15:0] & mask;
    bo   = (32'(am) < (32'(bm) + 32'(bin)));
    ov   = (am[w-1] != bm[w-1]) && (dd[w-1] != am[w-1]);
    return {ov, bo, dd};
  endfunction

  // ---------------- driver helpers ----------------
  function automatic int n_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 4 : 1;
  endfunction

  function automatic int w_of(input int sel);
    return (sel == 1) ? 16 : 8;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy8 : (sel == 1) ? busy16 : busy1;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done8 : (sel == 1) ? done16 : done1;
  endfunction

  function automatic logic get_dbg(input int sel);
    return (sel == 0) ? dbg8 : (sel == 1) ? dbg16 : dbg1;
  endfunction

  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic st);
    case (sel)
      0: begin a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = st; end
      1: begin a16 = a; b16 = b; bin16 = bin; start16 = st; end
      default: begin a1 = a[7:0]; b1 = b[7:0]; bin1 = bin; start1 = st; end
    endcase
  endtask

  task automatic push_exp(input int sel, input logic [17:0] e);
    case (sel)
      0: exp8_q.push_back(e);
      1: exp16_q.push_back(e);
      default: exp1_q.push_back(e);
    endcase
  endtask

  // One complete operation: accept, scramble the operand inputs, then time
  // busy and done against N.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [17:0] e);
    int c;
    int busy_cnt;
    @(negedge clk);
    drive(sel, a, b, bin, 1'b1);
    @(posedge clk);
    push_exp(sel, e);
    #1;
    drive(sel, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    c = 0;
    busy_cnt = 0;
    while (!get_done(sel) && c < 40) begin
      @(negedge clk);
      c++;
      if (get_busy(sel)) busy_cnt++;
      if (c == 1) chk($sformatf("dbg_run_sel%0d", sel), 32'(get_dbg(sel)), 32'd1);
    end
    if (!get_done(sel)) begin
      chk($sformatf("timeout_sel%0d", sel), 32'(c), 32'(n_of(sel) + 1));
    end else begin
      chk($sformatf("latency_sel%0d", sel), 32'(c - 1), 32'(n_of(sel)));
      chk($sformatf("busy_cycles_sel%0d", sel), 32'(busy_cnt), 32'(n_of(sel)));
      chk($sformatf("busy_at_done_sel%0d", sel), 32'(get_busy(sel)), 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin
    int c;
    logic d_hold_ok;

    vecs[0] = '{0, 16'h0035, 16'h0012, 1'b0, 16'h0023, 1'b0, 1'b0};
    vecs[1] = '{0, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1};
    vecs[3] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[4] = '{0, 16'h007F, 16'h00FF, 1'b0, 16'h0080, 1'b1, 1'b1};
    vecs[5] = '{1, 16'h1234, 16'h4321, 1'b1, 16'hCF12, 1'b1, 1'b0};
    vecs[6] = '{1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[7] = '{2, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1};
    vecs[8] = '{2, 16'h0005, 16'h0007, 1'b1, 16'h00FD, 1'b1, 1'b0};

    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(2, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs8",  32'({dbg8, busy8, done8, ovf8, bout8, d8}), 32'd0);
    chk("reset_outs16", 32'({dbg16, busy16, done16, ovf16, bout16, d16}), 32'd0);
    chk("reset_outs1",  32'({dbg1, busy1, done1, ovf1, bout1, d1}), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].bin,
             {vecs[i].ov, vecs[i].bo, vecs[i].d});

    // Random vectors against the model
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 8; k++) begin
        logic [15:0] ra, rb;
        logic        rbin;
        ra   = 16'($urandom_range(0, 65535));
        rb   = 16'($urandom_range(0, 65535));
        rbin = 1'($urandom_range(0, 1));
        if (w_of(s) == 8) begin
          ra = ra & 16'h00FF;
          rb = rb & 16'h00FF;
        end
        run_op(s, ra, rb, rbin, model(w_of(s), ra, rb, rbin));
      end
    end

    // Start protocol on the 8-bit serial instance:
    // op A = 0x35 - 0x12, a foreign start pulse mid-run, then start held
    // high through A's done so that op B is accepted one edge after EN.
    @(negedge clk);
    drive(0, 16'h0035, 16'h0012, 1'b0, 1'b1);
    @(posedge clk);
    exp8_q.push_back(model(8, 16'h0035, 16'h0012, 1'b0));
    #1 start8 = 1'b0;
    c = 0;
    while (!done8 && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 3) drive(0, 16'h00AA, 16'h000F, 1'b1, 1'b1);
      if (c == 4) start8 = 1'b0;
      if (c == 5) drive(0, 16'h0040, 16'h0005, 1'b1, 1'b1);
    end
    chk("protoA_latency", 32'(c - 1), 32'd8);
    chk("protoA_busy_at_done", 32'(busy8), 32'd0);
    @(posedge clk);
    exp8_q.push_back(model(8, 16'h0040, 16'h0005, 1'b1));
    #1 drive(0, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
    @(negedge clk);
    chk("protoB_accepted_at_en_plus1", 32'(busy8), 32'd1);
    start8 = 1'b0;
    d_hold_ok = (d8 == 8'h23);
    c = 1;
    while (!done8 && c < 40) begin
      @(negedge clk);
      c++;
      if (!done8 && d8 != 8'h23) d_hold_ok = 1'b0;
    end
    chk("protoB_d_holds_prev", 32'(d_hold_ok), 32'd1);
    chk("protoB_latency", 32'(c - 1), 32'd8);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    drive(0, 16'h0077, 16'h0011, 1'b0, 1'b1);
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outs", 32'({busy8, done8, ovf8, bout8, d8}), 32'd0);
    chk("midrun_reset_state", 32'(dbg8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrun_no_done_busy", 32'({busy8, done8}), 32'd0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h00FE});

    // Drain: every expected result must have been consumed
    repeat (4) @(negedge clk);
    chk("drain_q8",  32'(exp8_q.size()), 32'd0);
    chk("drain_q16", 32'(exp16_q.size()), 32'd0);
    chk("drain_q1",  32'(exp1_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
